// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants for the serial adder driver and its benches
//
// Exports:
//   state_t       : control FSM encoding (IDLE, CLEAR, SHIFT, DRAIN)
//   DEFAULT_WIDTH : default operand/result width

package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

endpackage

// File: rtl/serial_add_driver.sv
// rtl/serial_add_driver.sv - parallel-side initiator for the bit-serial Moore adder
//
// Latches two WIDTH-bit operands on start, clears the adder through ser_rst,
// streams the operands LSB-first on ser_a/ser_b, gathers the one-cycle-late
// Moore sum bits and presents {cout, result} with a single-cycle done pulse.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, op_a, op_b     : request and operands (sampled while ready=1)
//   ready, busy           : idle / working status (busy = ~ready)
//   ser_rst, ser_a, ser_b : drive the serial adder
//   ser_sum, ser_carry    : registered adder outputs
//   result, cout, done    : registered sum, carry-out and completion pulse

module serial_add_driver
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             ser_rst,
    output logic             ser_a,
    output logic             ser_b,
    input  logic             ser_sum,
    input  logic             ser_carry,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             done
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the low WIDTH-1 sum bits; the MSB arrives during DRAIN and goes
    // straight into result, so it never needs a storage slot here.
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    // Current adder sum bit placed above the collected bits: the upper
    // WIDTH-1 bits are the next accumulator, all WIDTH bits form the result.
    logic [WIDTH-1:0] acc_ins;
    assign acc_ins = {ser_sum, acc_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_LAST) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready   = (state_q == ST_IDLE);
        busy    = ~ready;
        // rst is ORed in so the adder is cleared in the very cycle we abort.
        ser_rst = rst | (state_q == ST_CLEAR);
        ser_a   = (state_q == ST_SHIFT) & a_sh_q[0];
        ser_b   = (state_q == ST_SHIFT) & b_sh_q[0];
    end

    // Datapath next-value logic
    always_comb begin
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d = op_a;
                    b_sh_d = op_b;
                end
            end
            ST_CLEAR: begin
                cnt_d = '0;
            end
            ST_SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                // The Moore adder output lags its input by one cycle, so the
                // first SHIFT cycle still shows the cleared state.
                if (cnt_q != '0) begin
                    acc_d = acc_ins[WIDTH-1:1];
                end
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
            ST_DRAIN: begin
                result_d = acc_ins;
                cout_d   = ser_carry;
                done_d   = 1'b1;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_add_driver.sv
// tb/tb_serial_add_driver.sv - self-checking bench for serial_add_driver (WIDTH 8 and 16)

module tb_serial_add_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;

    logic        ready8, busy8, ser_rst8, ser_a8, ser_b8, sum8, carry8, cout8, done8;
    logic [7:0]  result8;
    logic        ready16, busy16, ser_rst16, ser_a16, ser_b16, sum16, carry16, cout16, done16;
    logic [15:0] result16;

    serial_add_driver #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_a(a8), .op_b(b8),
        .ready(ready8), .busy(busy8), .ser_rst(ser_rst8), .ser_a(ser_a8), .ser_b(ser_b8),
        .ser_sum(sum8), .ser_carry(carry8), .result(result8), .cout(cout8), .done(done8)
    );

    serial_add_driver #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op_a(a16), .op_b(b16),
        .ready(ready16), .busy(busy16), .ser_rst(ser_rst16), .ser_a(ser_a16), .ser_b(ser_b16),
        .ser_sum(sum16), .ser_carry(carry16), .result(result16), .cout(cout16), .done(done16)
    );

    // Behavioural Moore full adder: registered {carry,sum}, cleared by its rst.
    always @(posedge clk) begin
        if (ser_rst8) {carry8, sum8} <= 2'b00;
        else          {carry8, sum8} <= {1'b0, ser_a8} + {1'b0, ser_b8} + {1'b0, carry8};
        if (ser_rst16) {carry16, sum16} <= 2'b00;
        else           {carry16, sum16} <= {1'b0, ser_a16} + {1'b0, ser_b16} + {1'b0, carry16};
    end

    int checks = 0;
    int passed = 0;

    logic        sa [0:63];
    logic        sb [0:63];
    logic        sr [0:63];
    int          lat;
    logic [7:0]  r8;
    logic        c8;
    logic [15:0] r16;
    logic        c16;

    // Issue one 8-bit operation starting in the current cycle (cycle 0) and
    // return at the cycle where done is seen. With hold=1, start stays high
    // and the operands are changed mid-operation.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input bit hold);
        start8 = 1'b1; a8 = a; b8 = b; lat = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (cyc == 1 && !hold) start8 = 1'b0;
            if (cyc == 4 && hold) begin a8 = 8'h11; b8 = 8'h22; end
            sa[cyc] = ser_a8; sb[cyc] = ser_b8; sr[cyc] = ser_rst8;
            checks++;
            if (busy8 !== ~ready8) $display("FAIL busy8_vs_ready8: busy=%b ready=%b", busy8, ready8);
            else passed++;
            if (cyc > 0 && done8 === 1'b1) begin
                lat = cyc; r8 = result8; c8 = cout8;
                break;
            end
        end
        start8 = 1'b0;
        checks++;
        if (lat < 0) $display("FAIL done8_timeout: no done within 40 cycles, required done");
        else passed++;
    endtask

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b);
        start16 = 1'b1; a16 = a; b16 = b; lat = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (cyc == 1) start16 = 1'b0;
            checks++;
            if (busy16 !== ~ready16) $display("FAIL busy16_vs_ready16: busy=%b ready=%b", busy16, ready16);
            else passed++;
            if (cyc > 0 && done16 === 1'b1) begin
                lat = cyc; r16 = result16; c16 = cout16;
                break;
            end
        end
        start16 = 1'b0;
        checks++;
        if (lat < 0) $display("FAIL done16_timeout: no done within 60 cycles, required done");
        else passed++;
    endtask

    task automatic check_result8(input string name, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] exp;
        exp = {1'b0, a} + {1'b0, b};
        checks++;
        if ({c8, r8} !== exp) $display("FAIL %s_sum: got %h required %h", name, {c8, r8}, exp);
        else passed++;
        checks++;
        if (lat !== 11) $display("FAIL %s_latency: got %0d required 11", name, lat);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if ({ready8, busy8, ser_rst8, ser_a8, ser_b8, done8, cout8} !== 7'b1010000)
            $display("FAIL reset_ctrl: got %b required 1010000",
                     {ready8, busy8, ser_rst8, ser_a8, ser_b8, done8, cout8});
        else passed++;
        checks++;
        if (result8 !== 8'h00 || result16 !== 16'h0000)
            $display("FAIL reset_result: got %h/%h required 00/0000", result8, result16);
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ser_rst8 !== 1'b0 || ready8 !== 1'b1)
            $display("FAIL reset_release: ser_rst=%b ready=%b required 0/1", ser_rst8, ready8);
        else passed++;
    endtask

    task automatic test_basic();
        run_op8(8'h5A, 8'h3C, 1'b0);
        check_result8("basic", 8'h5A, 8'h3C);
        for (int c = 0; c <= 11; c++) begin
            checks++;
            if (sr[c] !== (c == 1)) $display("FAIL basic_ser_rst_c%0d: got %b required %b", c, sr[c], (c == 1));
            else passed++;
        end
    endtask

    task automatic test_stream();
        logic [7:0] ea, eb;
        ea = 8'hFF; eb = 8'h01;
        run_op8(ea, eb, 1'b0);
        check_result8("stream", ea, eb);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sa[i+2] !== ea[i] || sb[i+2] !== eb[i])
                $display("FAIL stream_bit%0d: got a=%b b=%b required a=%b b=%b", i, sa[i+2], sb[i+2], ea[i], eb[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        run_op8(8'hFF, 8'hFF, 1'b0);
        check_result8("b2b_first", 8'hFF, 8'hFF);
        checks++;
        if (ready8 !== 1'b1) $display("FAIL b2b_ready_on_done: got %b required 1", ready8);
        else passed++;
        run_op8(8'h00, 8'h00, 1'b0);
        check_result8("b2b_second", 8'h00, 8'h00);
    endtask

    task automatic test_start_while_busy();
        int pulses;
        run_op8(8'h0F, 8'h01, 1'b1);
        check_result8("busy_start", 8'h0F, 8'h01);
        pulses = (lat > 0) ? 1 : 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) $display("FAIL busy_start_pulses: got %0d required 1", pulses);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if (ser_rst8 !== 1'b1) $display("FAIL rstmid_ser_rst: got %b required 1", ser_rst8);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({ready8, busy8, done8, cout8} !== 4'b1000 || result8 !== 8'h00)
            $display("FAIL rstmid_state: got rdy/bsy/done/cout=%b result=%h required 1000/00",
                     {ready8, busy8, done8, cout8}, result8);
        else passed++;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL rstmid_no_done: got %0d pulses required 0", pulses);
        else passed++;
        run_op8(8'h80, 8'h80, 1'b0);
        check_result8("rstmid_fresh", 8'h80, 8'h80);
    endtask

    task automatic test_random();
        logic [7:0]  x8, y8;
        logic [15:0] x16, y16;
        logic [16:0] exp16;
        for (int n = 0; n < 1000; n++) begin
            x8 = 8'($urandom); y8 = 8'($urandom);
            run_op8(x8, y8, 1'b0);
            check_result8("rand8", x8, y8);
        end
        for (int n = 0; n < 1000; n++) begin
            x16 = 16'($urandom); y16 = 16'($urandom);
            exp16 = {1'b0, x16} + {1'b0, y16};
            run_op16(x16, y16);
            checks++;
            if ({c16, r16} !== exp16) $display("FAIL rand16_sum: got %h required %h", {c16, r16}, exp16);
            else passed++;
            checks++;
            if (lat !== 19) $display("FAIL rand16_latency: got %0d required 19", lat);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
